// File: rtl/min_cmp_scheduler.sv
// Purpose : minimum (and optionally its index) of NUM_IN unsigned operands, found with one shared comparator.
// Latency : out_valid rises NUM_IN-1 cycles after the input handshake.
// Backpr. : in_ready is low from acceptance until the cycle after the result handshake; the result holds while out_ready=0.
//
// Ports:
//   clk, rst_n           rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready    operand vector handshake; operand k at in_data[k*DATA_W +: DATA_W]
//   out_valid/out_ready  result handshake; out_min (and out_idx) are stable while out_valid=1
//   busy                 high while a job is being compared or its result is pending
//   out_idx              index of the winning operand, present only when MIN_IDX_EN is defined
//
// Build option: define MIN_IDX_EN to add the out_idx port and the index register.

module min_cmp_scheduler #(
   parameter  int DATA_W = 8,
   parameter  int NUM_IN = 3,
   localparam int IDX_W  = $clog2(NUM_IN)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [NUM_IN*DATA_W-1:0] in_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [DATA_W-1:0]        out_min,
   output logic                     busy
`ifdef MIN_IDX_EN
   ,
   output logic [IDX_W-1:0]         out_idx
`endif
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CMP  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_IN - 1);

   state_t              state;
   state_t              next_state;
   logic [DATA_W-1:0]   ops [NUM_IN];
   logic [DATA_W-1:0]   min_r;
   logic [IDX_W-1:0]    cnt;
   logic [DATA_W-1:0]   cur_op;
   logic                lt;
   logic                accept;
   logic                last_cmp;
`ifdef MIN_IDX_EN
   logic [IDX_W-1:0]    idx_r;
`endif

   // The one shared comparator: the operand selected by cnt against the running min.
   // Strict less-than keeps the earlier (lower) index on ties.
   assign cur_op   = ops[cnt];
   assign lt       = cur_op < min_r;
   assign accept   = in_valid && in_ready;
   assign last_cmp = (cnt == LAST_IDX);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state and handshake outputs
   always_comb begin
      next_state = state;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      busy       = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               next_state = CMP;
            end
         end
         CMP: begin
            busy = 1'b1;
            if (last_cmp) begin
               next_state = DONE;
            end
         end
         DONE: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            // IDLE (and in_ready) only on the following cycle, so no same-cycle re-accept.
            if (out_ready) begin
               next_state = IDLE;
            end
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // Operand capture, running minimum and result registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < NUM_IN; k++) begin
            ops[k] <= '0;
         end
         min_r   <= '0;
         cnt     <= '0;
         out_min <= '0;
`ifdef MIN_IDX_EN
         idx_r   <= '0;
         out_idx <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  for (int k = 0; k < NUM_IN; k++) begin
                     ops[k] <= in_data[k*DATA_W +: DATA_W];
                  end
                  min_r <= in_data[DATA_W-1:0];
                  cnt   <= IDX_W'(1);
`ifdef MIN_IDX_EN
                  idx_r <= '0;
`endif
               end
            end
            CMP: begin
               if (lt) begin
                  min_r <= cur_op;
`ifdef MIN_IDX_EN
                  idx_r <= cnt;
`endif
               end
               cnt <= cnt + IDX_W'(1);
               // Result registers load only here, so they keep the previous
               // result while the next job is being compared.
               if (last_cmp) begin
                  out_min <= lt ? cur_op : min_r;
`ifdef MIN_IDX_EN
                  out_idx <= lt ? cnt : idx_r;
`endif
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_min_cmp_scheduler.sv
// Directed bench for min_cmp_scheduler (DATA_W=8, NUM_IN=3).
// Expected minima/indices are hand-computed constants in each job call.

module tb_min_cmp_scheduler;

   localparam int DATA_W = 8;
   localparam int NUM_IN = 3;
   localparam int IDX_W  = $clog2(NUM_IN);

   logic                     clk;
   logic                     rst_n;
   logic                     in_valid;
   logic                     in_ready;
   logic [NUM_IN*DATA_W-1:0] in_data;
   logic                     out_valid;
   logic                     out_ready;
   logic [DATA_W-1:0]        out_min;
   logic                     busy;
`ifdef MIN_IDX_EN
   logic [IDX_W-1:0]         out_idx;
`endif

   int checks   = 0;
   int failures = 0;

   min_cmp_scheduler #(
      .DATA_W (DATA_W),
      .NUM_IN (NUM_IN)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_min   (out_min),
      .busy      (busy)
`ifdef MIN_IDX_EN
      ,
      .out_idx   (out_idx)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // One job: present at a negedge, accepted at the next posedge, then
   // hold out_ready low for 'hold' cycles once out_valid is up.
   // With 'noise' set, in_valid toggles and in_data changes during CMP.
   task automatic run_job(input string tag,
                          input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                          input logic [7:0] emin, input logic [1:0] eidx,
                          input int hold, input bit noise);
      int n;
      @(negedge clk);
      check_eq({tag, ".in_ready_idle"}, in_ready, 1'b1);
      in_data   = {c, b, a};
      in_valid  = 1'b1;
      out_ready = (hold == 0);
      @(negedge clk);
      in_valid = 1'b0;
      check_eq({tag, ".busy_cmp"}, busy, 1'b1);
      check_eq({tag, ".in_ready_cmp"}, in_ready, 1'b0);
      n = 0;
      while (!out_valid && n < 10) begin
         if (noise) begin
            in_valid = ~in_valid;
            in_data  = 24'h010101 + 24'(n);
         end
         @(negedge clk);
         n++;
      end
      in_valid = 1'b0;
      check_eq({tag, ".latency"}, n, NUM_IN - 1);
      check_eq({tag, ".out_min"}, out_min, emin);
`ifdef MIN_IDX_EN
      check_eq({tag, ".out_idx"}, out_idx, eidx);
`endif
      check_eq({tag, ".in_ready_done"}, in_ready, 1'b0);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check_eq({tag, ".hold_valid"}, out_valid, 1'b1);
         check_eq({tag, ".hold_min"}, out_min, emin);
         check_eq({tag, ".hold_in_ready"}, in_ready, 1'b0);
      end
      out_ready = 1'b1;
      @(negedge clk);
      check_eq({tag, ".valid_after_hs"}, out_valid, 1'b0);
      check_eq({tag, ".in_ready_after_hs"}, in_ready, 1'b1);
      check_eq({tag, ".busy_after_hs"}, busy, 1'b0);
      check_eq({tag, ".min_kept"}, out_min, emin);
      if (eidx > 2'd2) $display("note: bad index constant in %s", tag);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b1;
      repeat (3) @(negedge clk);

      // Reset state
      check_eq("rst.in_ready", in_ready, 1'b1);
      check_eq("rst.out_valid", out_valid, 1'b0);
      check_eq("rst.busy", busy, 1'b0);
      check_eq("rst.out_min", out_min, 8'd0);
`ifdef MIN_IDX_EN
      check_eq("rst.out_idx", out_idx, 2'd0);
`endif
      rst_n = 1'b1;
      @(negedge clk);
      check_eq("rel.out_valid", out_valid, 1'b0);

      //       tag        a    b    c    min  idx hold noise
      run_job("j1",      10,  15,  35,  10,  0,  0,   0);
      run_job("j2a",     50,  15,  35,  15,  1,  0,   0);
      run_job("j2b",     50,  44,  45,  44,  1,  0,   0);
      run_job("j2c",     50,  44,  10,  10,  2,  0,   0);
      run_job("tie",      7,   7,   7,   7,  0,  0,   0);
      run_job("zero",     0, 255,   0,   0,  0,  0,   0);
      run_job("top",    255, 255, 254, 254,  2,  0,   0);
      run_job("hold",   200, 100, 150, 100,  1,  5,   0);
      run_job("noise",   40,  30,  20,  20,  2,  0,   1);

      // Reset in the middle of CMP
      @(negedge clk);
      in_data  = {8'd5, 8'd6, 8'd9};
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      check_eq("mid.busy_before", busy, 1'b1);
      rst_n = 1'b0;
      #1;
      check_eq("mid.out_valid", out_valid, 1'b0);
      check_eq("mid.in_ready", in_ready, 1'b1);
      check_eq("mid.busy", busy, 1'b0);
      check_eq("mid.out_min", out_min, 8'd0);
      @(negedge clk);
      rst_n = 1'b1;
      n = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (out_valid) n++;
      end
      check_eq("mid.no_pulse", n, 0);
      run_job("post",     3,   2,   1,   1,  2,  0,   0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
